// File: rtl/tilexy_miss_sched.sv
// Miss scheduler: picks queue head or a new miss in age order and injects it on the fwd/back ring.
// One injection per cycle, registered (latency 1); strict ordering, per-direction ring credits.
module tilexy_miss_sched #(
  parameter int tile_X  = 0,
  parameter int tile_Y  = 0,
  parameter int IDX     = 0,
  parameter int DEPTH   = 8,
  parameter int CREDITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       missue_en,
  input  logic [2:0][38:0] missue_addr,
  input  logic [2:0][39:0] missue_phy,
  output logic             missue_stall,
  input  logic [1:0]       credit_ret,
  output logic             inj_en,
  output logic             inj_fwd,
  output logic [38:0]      inj_addr,
  output logic [39:0]      inj_phy,
  output logic             ovf_err
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [1:0] TX        = 2'(tile_X);
  localparam logic [1:0] TY        = 2'(tile_Y);
  localparam logic [3:0] CMAX      = 4'(CREDITS);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] STALL_TH = (AW+1)'(DEPTH - 3);

  function automatic logic is_fwd(input logic [3:0] a);
    return (IDX < 2) ? (a[1:0] > TX) : (a[3:2] > TY);
  endfunction

  // Returns {saturated, next_count}; inc and dec together cancel.
  function automatic logic [4:0] cr_next(input logic [3:0] cnt, input logic inc, input logic dec);
    logic [4:0] r;
    r = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == CMAX) r = {1'b1, cnt};
      else             r = {1'b0, cnt + 4'd1};
    end else if (dec && !inc) begin
      r = {1'b0, cnt - 4'd1};
    end
    return r;
  endfunction

  logic [38:0]   q_addr [DEPTH];
  logic [39:0]   q_phy  [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   occ;
  logic [3:0]    fwd_cr, back_cr;

  logic          head_vld, cand_vld, cand_fwd, inject, pop, drop;
  logic [1:0]    cand_idx;
  logic [38:0]   cand_addr;
  logic [39:0]   cand_phy;
  logic [2:0]    wr_en;
  logic [AW-1:0] wr_slot [3];
  logic [AW:0]   space, n_push;
  logic [4:0]    fwd_nxt, back_nxt;

  always_comb begin
    head_vld  = (occ != '0);
    cand_vld  = head_vld;
    cand_idx  = 2'd3;
    cand_addr = q_addr[rd_ptr];
    cand_phy  = q_phy[rd_ptr];
    // Descending scan so the lowest valid index wins when the queue is empty.
    for (int i = 2; i >= 0; i--) begin
      if (!head_vld && missue_en[i]) begin
        cand_vld  = 1'b1;
        cand_idx  = 2'(i);
        cand_addr = missue_addr[i];
        cand_phy  = missue_phy[i];
      end
    end
    cand_fwd = is_fwd(cand_addr[3:0]);
    inject   = cand_vld && (cand_fwd ? (fwd_cr != 4'd0) : (back_cr != 4'd0));
    pop      = inject && head_vld;

    // A pop this cycle frees its slot for a same-cycle push.
    space  = DEPTH_C - occ + {{AW{1'b0}}, pop};
    n_push = '0;
    drop   = 1'b0;
    wr_en  = '0;
    for (int i = 0; i < 3; i++) begin
      wr_slot[i] = wr_ptr + n_push[AW-1:0];
      if (missue_en[i] && !(inject && !head_vld && cand_idx == 2'(i))) begin
        if (n_push < space) begin
          wr_en[i] = 1'b1;
          n_push   = n_push + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end

    fwd_nxt  = cr_next(fwd_cr,  credit_ret[1], inject &&  cand_fwd);
    back_nxt = cr_next(back_cr, credit_ret[0], inject && !cand_fwd);
    missue_stall = (occ > STALL_TH);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wr_en[i]) begin
        q_addr[wr_slot[i]] <= missue_addr[i];
        q_phy[wr_slot[i]]  <= missue_phy[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      fwd_cr   <= CMAX;
      back_cr  <= CMAX;
      inj_en   <= 1'b0;
      inj_fwd  <= 1'b0;
      inj_addr <= '0;
      inj_phy  <= '0;
      ovf_err  <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + n_push[AW-1:0];
      rd_ptr  <= rd_ptr + {{(AW-1){1'b0}}, pop};
      occ     <= occ + n_push - {{AW{1'b0}}, pop};
      fwd_cr  <= fwd_nxt[3:0];
      back_cr <= back_nxt[3:0];
      ovf_err <= ovf_err | drop | fwd_nxt[4] | back_nxt[4];
      inj_en  <= inject;
      if (inject) begin
        inj_fwd  <= cand_fwd;
        inj_addr <= cand_addr;
        inj_phy  <= cand_phy;
      end
    end
  end

endmodule

// File: tb/tb_tilexy_miss_sched.sv
// Directed bench for tilexy_miss_sched with an in-order injection scoreboard.
module tb_tilexy_miss_sched;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       missue_en;
  logic [2:0][38:0] missue_addr;
  logic [2:0][39:0] missue_phy;
  logic             missue_stall;
  logic [1:0]       credit_ret;
  logic             inj_en, inj_fwd, ovf_err;
  logic [38:0]      inj_addr;
  logic [39:0]      inj_phy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        fwd;
    logic [38:0] addr;
    logic [39:0] phy;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  tilexy_miss_sched #(.tile_X(1), .tile_Y(0), .IDX(0), .DEPTH(8), .CREDITS(4)) dut (
    .clk(clk), .rst(rst),
    .missue_en(missue_en), .missue_addr(missue_addr), .missue_phy(missue_phy),
    .missue_stall(missue_stall), .credit_ret(credit_ret),
    .inj_en(inj_en), .inj_fwd(inj_fwd), .inj_addr(inj_addr), .inj_phy(inj_phy),
    .ovf_err(ovf_err)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample #1 later, check inj_en and compare any injection with the scoreboard.
  task automatic tick(input bit exp_en);
    exp_t e;
    @(posedge clk);
    #1;
    chk("inj_en", 80'(inj_en), 80'(exp_en));
    if (inj_en) begin
      if (sb.size() == 0) begin
        chk("spurious_inj", 80'(inj_en), 80'(0));
      end else begin
        e = sb.pop_front();
        chk("inj_fwd",  80'(inj_fwd),  80'(e.fwd));
        chk("inj_addr", 80'(inj_addr), 80'(e.addr));
        chk("inj_phy",  80'(inj_phy),  80'(e.phy));
      end
    end
  endtask

  // Drive one cycle of requests; d* are addr[1:0] (fwd when >1 with tile_X=1); keep marks
  // requests that will eventually be injected and so belong in the scoreboard.
  task automatic issue(input logic [2:0] en, input logic [1:0] d0, input logic [1:0] d1,
                       input logic [1:0] d2, input logic [2:0] keep, input bit exp_en);
    logic [1:0] d [3];
    exp_t e;
    d[0] = d0; d[1] = d1; d[2] = d2;
    for (int i = 0; i < 3; i++) begin
      e.addr = {5'h0, 32'($urandom()), d[i]};
      e.phy  = {8'h0, 32'($urandom())};
      e.fwd  = (d[i] > 2'd1);
      missue_addr[i] = e.addr;
      missue_phy[i]  = e.phy;
      if (en[i] && keep[i]) sb.push_back(e);
    end
    missue_en = en;
    tick(exp_en);
    missue_en = 3'b000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    missue_en = 3'b000;
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    rst = 1'b1;
    missue_en = 3'b000;
    missue_addr = '0;
    missue_phy = '0;
    credit_ret = 2'b00;
    do_reset();
    chk("rst_inj_fwd",  80'(inj_fwd),  80'(0));
    chk("rst_inj_addr", 80'(inj_addr), 80'(0));
    chk("rst_inj_phy",  80'(inj_phy),  80'(0));
    chk("rst_ovf",      80'(ovf_err),  80'(0));
    chk("rst_stall",    80'(missue_stall), 80'(0));
    tick(1'b0);

    // Single fwd miss injects with latency 1; then return that fwd credit.
    issue(3'b001, 2'd2, 2'd0, 2'd0, 3'b001, 1'b1);
    credit_ret = 2'b10; tick(1'b0); credit_ret = 2'b00;

    // Three back misses in one cycle inject on three consecutive edges in index order.
    issue(3'b111, 2'd0, 2'd1, 2'd0, 3'b111, 1'b1);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    chk("sb_empty_a", 80'(sb.size()), 80'(0));
    credit_ret = 2'b01; repeat (3) tick(1'b0); credit_ret = 2'b00;

    // Exhaust fwd credits; fifth fwd waits and blocks a younger back miss.
    repeat (4) issue(3'b001, 2'd3, 2'd0, 2'd0, 3'b001, 1'b1);
    issue(3'b001, 2'd2, 2'd0, 2'd0, 3'b001, 1'b0);
    issue(3'b001, 2'd0, 2'd0, 2'd0, 3'b001, 1'b0);
    tick(1'b0);
    tick(1'b0);
    credit_ret = 2'b10; tick(1'b0); credit_ret = 2'b00;
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    chk("sb_empty_b", 80'(sb.size()), 80'(0));
    credit_ret = 2'b11; tick(1'b0);
    credit_ret = 2'b10; repeat (3) tick(1'b0); credit_ret = 2'b00;

    // Injection and return in the same cycle at credit 2 leave exactly 2 more fwd slots.
    issue(3'b001, 2'd2, 2'd0, 2'd0, 3'b001, 1'b1);
    issue(3'b001, 2'd2, 2'd0, 2'd0, 3'b001, 1'b1);
    credit_ret = 2'b10;
    issue(3'b001, 2'd3, 2'd0, 2'd0, 3'b001, 1'b1);
    credit_ret = 2'b00;
    issue(3'b001, 2'd2, 2'd0, 2'd0, 3'b001, 1'b1);
    issue(3'b001, 2'd2, 2'd0, 2'd0, 3'b001, 1'b1);
    issue(3'b001, 2'd3, 2'd0, 2'd0, 3'b001, 1'b0);
    credit_ret = 2'b10; tick(1'b0); credit_ret = 2'b00;
    tick(1'b1);
    tick(1'b0);
    credit_ret = 2'b10; repeat (4) tick(1'b0); credit_ret = 2'b00;

    // Credit return at the maximum saturates and raises ovf_err.
    chk("ovf_before_sat", 80'(ovf_err), 80'(0));
    credit_ret = 2'b01; tick(1'b0); credit_ret = 2'b00;
    chk("ovf_sat", 80'(ovf_err), 80'(1));
    do_reset();
    chk("ovf_cleared", 80'(ovf_err), 80'(0));

    // Fill the queue with fwd credits at zero; stall at occupancy 6, overflow drops index 2.
    repeat (4) issue(3'b001, 2'd2, 2'd0, 2'd0, 3'b001, 1'b1);
    issue(3'b111, 2'd2, 2'd3, 2'd2, 3'b111, 1'b0);
    chk("stall_occ3", 80'(missue_stall), 80'(0));
    issue(3'b111, 2'd3, 2'd2, 2'd3, 3'b111, 1'b0);
    chk("stall_occ6", 80'(missue_stall), 80'(1));
    chk("ovf_occ6", 80'(ovf_err), 80'(0));
    issue(3'b111, 2'd2, 2'd2, 2'd2, 3'b011, 1'b0);
    chk("ovf_drop", 80'(ovf_err), 80'(1));
    chk("stall_full", 80'(missue_stall), 80'(1));
    credit_ret = 2'b10;
    tick(1'b0);
    repeat (8) tick(1'b1);
    credit_ret = 2'b00;
    tick(1'b0);
    chk("sb_empty_c", 80'(sb.size()), 80'(0));
    chk("stall_drained", 80'(missue_stall), 80'(0));
    do_reset();

    // Reset with 5 queued entries discards them and restores credits; credit_ret in reset ignored.
    repeat (4) issue(3'b001, 2'd3, 2'd0, 2'd0, 3'b001, 1'b1);
    issue(3'b111, 2'd2, 2'd2, 2'd2, 3'b111, 1'b0);
    issue(3'b011, 2'd2, 2'd2, 2'd0, 3'b011, 1'b0);
    chk("stall_occ5", 80'(missue_stall), 80'(0));
    rst = 1'b1; credit_ret = 2'b11;
    tick(1'b0);
    rst = 1'b0; credit_ret = 2'b00;
    sb.delete();
    tick(1'b0);
    tick(1'b0);
    chk("stall_after_rst", 80'(missue_stall), 80'(0));
    chk("ovf_after_rst", 80'(ovf_err), 80'(0));
    repeat (4) issue(3'b001, 2'd2, 2'd0, 2'd0, 3'b001, 1'b1);
    issue(3'b001, 2'd3, 2'd0, 2'd0, 3'b001, 1'b0);
    tick(1'b0);
    chk("ovf_end", 80'(ovf_err), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
